fft_stage_sequencer: RTL and testbench

Control FSM that drives the FFT butterfly argument path. On a start pulse it walks every stage (0 to log2(N)-1) and every butterfly pair (0 to N/2-1), presenting one `stage`/`pair_id` per accepted cycle to the argument generator's `i_valid`/`stage`/`pair_id` inputs. Between stages it stalls until the previous stage's results have drained back to sample RAM, so a stage never reads data that has not yet been written. It then signals completion.

---
 rtl/fft_stage_sequencer.sv | 154 +++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// FFT stage/pair issue sequencer: walks every stage and butterfly pair, then stalls between stages until results drain.
// Optional FFT_SEQ_WB_COUNT_EN: end each drain on counted write-backs instead of a fixed DRAIN_CYCLES wait.
module fft_stage_sequencer #(
  parameter int N             = 32,
  parameter int DRAIN_CYCLES  = 4,
  parameter int stage_width   = $clog2($clog2(N)),
  parameter int pair_id_width = $clog2(N/2)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  input  logic                     i_hold,
  input  logic                     i_wb_valid,
  output logic                     o_valid,
  output logic [stage_width-1:0]   o_stage,
  output logic [pair_id_width-1:0] o_pair_id,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam logic [stage_width-1:0]   LAST_STAGE = stage_width'($clog2(N) - 1);
  localparam logic [pair_id_width-1:0] LAST_PAIR  = pair_id_width'(N/2 - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                   state_reg, state_next;
  logic [stage_width-1:0]   stage_reg, stage_next;
  logic [pair_id_width-1:0] pair_reg, pair_next;
  logic                     enter_issue;
  logic                     enter_drain;
  logic                     drain_exit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      stage_reg <= '0;
      pair_reg  <= '0;
    end else begin
      state_reg <= state_next;
      stage_reg <= stage_next;
      pair_reg  <= pair_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    stage_next  = stage_reg;
    pair_next   = pair_reg;
    enter_issue = 1'b0;
    enter_drain = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          state_next  = ISSUE;
          stage_next  = '0;
          pair_next   = '0;
          enter_issue = 1'b1;
        end
      end
      ISSUE: begin
        if (!i_hold) begin
          if (pair_reg == LAST_PAIR) begin
            pair_next   = '0;
            state_next  = DRAIN;
            enter_drain = 1'b1;
          end else begin
            pair_next = pair_reg + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_exit) begin
          if (stage_reg == LAST_STAGE) begin
            state_next = DONE;
            stage_next = '0;
          end else begin
            state_next  = ISSUE;
            stage_next  = stage_reg + 1'b1;
            enter_issue = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef FFT_SEQ_WB_COUNT_EN
  localparam logic [pair_id_width:0] WB_FULL = (pair_id_width + 1)'(N/2);

  logic [pair_id_width:0] wb_cnt_reg, wb_cnt_inc, wb_cnt_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_cnt_reg <= '0;
    end else begin
      wb_cnt_reg <= wb_cnt_next;
    end
  end

  // The pulse arriving this cycle already counts, so the next stage issues the cycle after the last write-back.
  always_comb begin
    wb_cnt_inc = wb_cnt_reg;
    if ((state_reg == ISSUE || state_reg == DRAIN) && i_wb_valid && (wb_cnt_reg != WB_FULL)) begin
      wb_cnt_inc = wb_cnt_reg + 1'b1;
    end
  end

  assign wb_cnt_next = enter_issue ? '0 : wb_cnt_inc;
  assign drain_exit  = (wb_cnt_inc == WB_FULL);

  logic unused_drain_flag;
  assign unused_drain_flag = enter_drain;
`else
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  logic [DRAIN_W-1:0] drain_reg, drain_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      drain_reg <= '0;
    end else begin
      drain_reg <= drain_next;
    end
  end

  // Loaded with DRAIN_CYCLES-1 so the exit on zero gives exactly DRAIN_CYCLES cycles in DRAIN.
  always_comb begin
    drain_next = drain_reg;
    if (enter_drain) begin
      drain_next = DRAIN_LOAD;
    end else if (state_reg == DRAIN && drain_reg != '0) begin
      drain_next = drain_reg - 1'b1;
    end
  end

  assign drain_exit = (drain_reg == '0);

  logic unused_wb_valid;
  assign unused_wb_valid = i_wb_valid;
`endif

  assign o_valid   = (state_reg == ISSUE) && !i_hold;
  assign o_stage   = stage_reg;
  assign o_pair_id = pair_reg;
  assign o_busy    = (state_reg == ISSUE) || (state_reg == DRAIN);
  assign o_done    = (state_reg == DONE);

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer at N=8, DRAIN_CYCLES=4: plain run, issue holds, ignored inputs, mid-run reset.
module tb_fft_stage_sequencer;

  logic       clk;
  logic       reset;
  logic       i_start;
  logic       i_hold;
  logic       i_wb_valid;
  logic       o_valid;
  logic [1:0] o_stage;
  logic [1:0] o_pair_id;
  logic       o_busy;
  logic       o_done;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;

  fft_stage_sequencer #(
    .N            (8),
    .DRAIN_CYCLES (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (i_start),
    .i_hold     (i_hold),
    .i_wb_valid (i_wb_valid),
    .o_valid    (o_valid),
    .o_stage    (o_stage),
    .o_pair_id  (o_pair_id),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enter the next cycle: inputs set after this are sampled at the following rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all(input logic ev, input logic [1:0] es, input logic [1:0] ep,
                           input logic eb, input logic ed);
    #1;
    check("o_valid",   8'(o_valid),   8'(ev));
    check("o_stage",   8'(o_stage),   8'(es));
    check("o_pair_id", 8'(o_pair_id), 8'(ep));
    check("o_busy",    8'(o_busy),    8'(eb));
    check("o_done",    8'(o_done),    8'(ed));
  endtask

  // Hold-free schedule, t cycles after the cycle that carried i_start: three stages of
  // 4 issues + 4 drain cycles each (t=1..24), then o_done at t=25.
  task automatic expect_run(input int t);
    logic       ev, eb, ed;
    logic [1:0] es, ep;
    int         ph;
    ev = 1'b0; eb = 1'b0; ed = 1'b0; es = 2'd0; ep = 2'd0;
    if (t >= 1 && t <= 24) begin
      ph = (t - 1) % 8;
      eb = 1'b1;
      es = 2'((t - 1) / 8);
      ev = (ph < 4);
      ep = ev ? 2'(ph) : 2'd0;
    end
    ed = (t == 25);
    check_all(ev, es, ep, eb, ed);
  endtask

  initial begin
    reset      = 1'b0;
    i_start    = 1'b0;
    i_hold     = 1'b0;
    i_wb_valid = 1'b0;

    // Reset state.
    repeat (3) begin
      next_cycle();
      check_all(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    end
    next_cycle();
    reset = 1'b1;
    check_all(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

    // Run 1: start in cycle 0, no holds; done lands in cycle 25 only.
    for (int c = 0; c <= 30; c++) begin
      next_cycle();
      i_start = (c == 0);
      i_hold  = 1'b0;
      expect_run(c);
    end

    // Run 2: hold in cycles 2-3 freezes pair 1 and shifts everything after by two cycles.
    for (int c = 0; c <= 32; c++) begin
      next_cycle();
      i_start = (c == 0);
      i_hold  = (c == 2 || c == 3);
      if (c <= 1)      expect_run(c);
      else if (c <= 3) check_all(1'b0, 2'd0, 2'd1, 1'b1, 1'b0);
      else             expect_run(c - 2);
    end

    // Run 3: hold in IDLE, DRAIN and DONE is ignored; a second start in cycle 10 is ignored.
    for (int c = 0; c <= 30; c++) begin
      next_cycle();
      i_start    = (c == 0 || c == 10);
      i_hold     = (c == 0 || c == 6 || c == 7 || c == 25);
      i_wb_valid = (c % 3 == 0);
      expect_run(c);
    end
    i_wb_valid = 1'b0;

    // Run 4: reset in cycle 11 clears everything without a done; a fresh start runs from stage 0.
    for (int c = 0; c <= 50; c++) begin
      next_cycle();
      i_start = (c == 0 || c == 20);
      i_hold  = 1'b0;
      reset   = (c == 11) ? 1'b0 : 1'b1;
      if (c <= 11)      expect_run(c);
      else if (c <= 20) check_all(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
      else              expect_run(c - 20);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
